// File: rtl/color_sequencer.sv
// Colour sequencer: steps a 7-entry colour table on the darkest point of the breath and
// cycles CYCLE -> HOLD -> OFF on a debounced button press.
// Latency: rgb_o updates 1 cycle after breath_i falls; mode_o updates 2+DEBOUNCE_CYCLES+1 cycles after btn_i settles.
// Backpressure: none; free-running datapath, every input is sampled every clk_div_i cycle.
//
// Ports:
//   clk_div_i  in   1  clock shared with the breather (15.625 MHz)
//   rst_i      in   1  asynchronous, active-high reset
//   btn_i      in   1  raw, bouncy, asynchronous push-button (active-high)
//   breath_i   in   1  breather clk_div_o, synchronous to clk_div_i; 1->0 marks the darkest point
//   rgb_o      out  3  registered colour {R,G,B} for the breather
//   mode_o     out  2  registered mode: 0=CYCLE, 1=HOLD, 2=OFF
module color_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 312500,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk_div_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       breath_i,
  output logic [2:0] rgb_o,
  output logic [1:0] mode_o
);

  typedef enum logic [1:0] {
    MODE_CYCLE = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_OFF   = 2'd2
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'd6;

  // Colour table; index 7 is unreachable, the default only keeps the decode total.
  function automatic logic [2:0] color_of(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b001;
      3'd1:    c = 3'b010;
      3'd2:    c = 3'b100;
      3'd3:    c = 3'b011;
      3'd4:    c = 3'b110;
      3'd5:    c = 3'b101;
      3'd6:    c = 3'b111;
      default: c = 3'b001;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             breath_q,   breath_d;
  logic             edge_arm_q, edge_arm_d;
  logic             btn_s1_q,   btn_s1_d;
  logic             btn_s2_q,   btn_s2_d;
  logic             stable_q,   stable_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             press_q,    press_d;
  mode_e            mode_q,     mode_d;
  logic [2:0]       idx_q,      idx_d;
  logic [2:0]       rgb_q,      rgb_d;

  logic             fall;

  // ---------------------------------------------------------------------------
  // Breath edge detect
  // ---------------------------------------------------------------------------
  // breath_q resets to 1, which is not a real sample of breath_i. edge_arm_q
  // masks the first cycle after reset so a low breath_i at release is not
  // mistaken for a falling edge.
  always_comb begin
    breath_d   = breath_i;
    edge_arm_d = 1'b1;
  end

  assign fall = edge_arm_q & breath_q & ~breath_i;

  // ---------------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------------
  // The counter runs only while the synchronised level disagrees with the
  // accepted level; a single agreeing cycle clears it, so bounces shorter than
  // DEBOUNCE_CYCLES never reach stable_q. press_q is registered, so the mode
  // changes one cycle after the level is accepted.
  always_comb begin
    btn_s1_d = btn_i;
    btn_s2_d = btn_s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (btn_s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = btn_s2_q;
        press_d  = btn_s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= MODE_CYCLE;
    end else begin
      mode_q <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    if (press_q) begin
      case (mode_q)
        MODE_CYCLE: mode_d = MODE_HOLD;
        MODE_HOLD:  mode_d = MODE_OFF;
        default:    mode_d = MODE_CYCLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: outputs (colour index and colour word)
  // ---------------------------------------------------------------------------
  // The fall action is decided by the current mode; the press action is
  // applied afterwards so that a simultaneous press overrides only the colour
  // word of the mode being entered (OFF blanks, CYCLE restores table[idx]).
  always_comb begin
    idx_d = idx_q;
    rgb_d = rgb_q;

    if (fall) begin
      case (mode_q)
        MODE_CYCLE: begin
          idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          rgb_d = color_of(idx_d);
        end
        MODE_OFF: rgb_d = 3'b000;
        default:  ;
      endcase
    end

    if (press_q) begin
      case (mode_q)
        MODE_HOLD: rgb_d = 3'b000;
        MODE_OFF:  rgb_d = color_of(idx_q);
        default:   ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      breath_q   <= 1'b1;
      edge_arm_q <= 1'b0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      stable_q   <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      idx_q      <= 3'd0;
      rgb_q      <= 3'b001;
    end else begin
      breath_q   <= breath_d;
      edge_arm_q <= edge_arm_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      press_q    <= press_d;
      idx_q      <= idx_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb_o  = rgb_q;
  assign mode_o = mode_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Testbench for color_sequencer: directed scenarios followed by randomized
// button/breath activity, all checked against a behavioural model.
module tb_color_sequencer;

  localparam int DEB = 4;

  logic       clk_div_i = 1'b0;
  logic       rst_i;
  logic       btn_i;
  logic       breath_i;
  logic [2:0] rgb_o;
  logic [1:0] mode_o;

  int tests = 0;
  int fails = 0;

  color_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3)
  ) dut (
    .clk_div_i(clk_div_i),
    .rst_i    (rst_i),
    .btn_i    (btn_i),
    .breath_i (breath_i),
    .rgb_o    (rgb_o),
    .mode_o   (mode_o)
  );

  always #5 clk_div_i = ~clk_div_i;

  // ---------------- behavioural model ----------------
  logic [2:0] color_tab [7];
  int         m_mode;      // 0 CYCLE, 1 HOLD, 2 OFF
  int         m_idx;
  logic [2:0] m_rgb;
  logic       m_stable;
  int         m_run;       // consecutive cycles the synchronised level disagreed
  logic       m_pending;   // press accepted, takes effect next cycle
  logic       m_prev_breath;
  logic       m_prev_vld;
  logic       hist [$];    // button samples still in the 2-cycle synchroniser

  task automatic model_reset();
    m_mode        = 0;
    m_idx         = 0;
    m_rgb         = 3'b001;
    m_stable      = 1'b0;
    m_run         = 0;
    m_pending     = 1'b0;
    m_prev_breath = 1'b1;
    m_prev_vld    = 1'b0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  task automatic model_step();
    logic press_now;
    logic fall;
    logic d;
    if (rst_i) begin
      model_reset();
    end else begin
      press_now     = m_pending;
      m_pending     = 1'b0;
      fall          = m_prev_vld && m_prev_breath && !breath_i;
      m_prev_breath = breath_i;
      m_prev_vld    = 1'b1;

      hist.push_back(btn_i);
      d = hist.pop_front();
      if (d != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = d;
          m_run    = 0;
          if (d) m_pending = 1'b1;
        end
      end else begin
        m_run = 0;
      end

      if (fall) begin
        if (m_mode == 0) begin
          m_idx = (m_idx + 1) % 7;
          m_rgb = color_tab[m_idx];
        end else if (m_mode == 2) begin
          m_rgb = 3'b000;
        end
      end

      if (press_now) begin
        m_mode = (m_mode + 1) % 3;
        if (m_mode == 2)      m_rgb = 3'b000;
        else if (m_mode == 0) m_rgb = color_tab[m_idx];
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div_i);
    model_step();
    #1;
    chk("model_rgb",  {1'b0, rgb_o},  {1'b0, m_rgb});
    chk("model_mode", {2'b0, mode_o}, 4'(m_mode));
  endtask

  task automatic do_fall();
    breath_i = 1'b1;
    tick();
    tick();
    breath_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic press_release(input int hold, input int gap);
    btn_i = 1'b1;
    repeat (hold) tick();
    btn_i = 1'b0;
    repeat (gap) tick();
  endtask

  logic [2:0] exp_seq [8];

  initial begin
    color_tab[0] = 3'b001; color_tab[1] = 3'b010; color_tab[2] = 3'b100;
    color_tab[3] = 3'b011; color_tab[4] = 3'b110; color_tab[5] = 3'b101;
    color_tab[6] = 3'b111;
    exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b011; exp_seq[3] = 3'b110;
    exp_seq[4] = 3'b101; exp_seq[5] = 3'b111; exp_seq[6] = 3'b001; exp_seq[7] = 3'b010;

    // ---- reset ----
    btn_i    = 1'b0;
    breath_i = 1'b1;
    rst_i    = 1'b1;
    model_reset();
    #3;
    chk("reset_rgb",  {1'b0, rgb_o}, 4'b0001);
    chk("reset_mode", {2'b0, mode_o}, 4'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    tick();

    // ---- 1: eight falls in CYCLE, 1-cycle latency ----
    for (int i = 0; i < 8; i++) begin
      breath_i = 1'b1;
      tick();
      tick();
      breath_i = 1'b0;
      tick();
      chk("t1_step", {1'b0, rgb_o}, {1'b0, exp_seq[i]});
      tick();
    end

    // ---- 2: bounces of 1..3 cycles produce no press ----
    for (int k = 1; k <= 3; k++) begin
      btn_i = 1'b1;
      repeat (k) tick();
      btn_i = 1'b0;
      repeat (2) tick();
    end
    repeat (8) tick();
    chk("t2_mode", {2'b0, mode_o}, 4'd0);

    // ---- 3: long hold gives exactly one press at cycle 7 ----
    btn_i = 1'b1;
    repeat (6) tick();
    chk("t3_before", {2'b0, mode_o}, 4'd0);
    tick();
    chk("t3_press", {2'b0, mode_o}, 4'd1);
    repeat (13) tick();
    chk("t3_held", {2'b0, mode_o}, 4'd1);
    btn_i = 1'b0;
    repeat (10) tick();
    do_fall();
    do_fall();
    chk("t3_hold_rgb", {1'b0, rgb_o}, 4'b0010);

    // ---- 4: OFF blanks, CYCLE restores and resumes ----
    press_release(10, 10);
    chk("t4_off_mode", {2'b0, mode_o}, 4'd2);
    chk("t4_off_rgb",  {1'b0, rgb_o}, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      do_fall();
      chk("t4_off_fall", {1'b0, rgb_o}, 4'b0000);
    end
    press_release(10, 10);
    chk("t4_cyc_mode", {2'b0, mode_o}, 4'd0);
    chk("t4_restore",  {1'b0, rgb_o}, 4'b0010);
    do_fall();
    chk("t4_advance",  {1'b0, rgb_o}, 4'b0100);

    // ---- 5: press on the same cycle as a fall at idx=2 ----
    btn_i    = 1'b1;
    breath_i = 1'b1;
    repeat (6) tick();
    breath_i = 1'b0;
    tick();
    chk("t5_rgb",  {1'b0, rgb_o}, 4'b0011);
    chk("t5_mode", {2'b0, mode_o}, 4'd1);
    btn_i    = 1'b0;
    breath_i = 1'b1;
    repeat (10) tick();

    // ---- 6: reset mid-debounce at idx=5 ----
    press_release(10, 10);
    press_release(10, 10);
    do_fall();
    do_fall();
    chk("t6_pre_rgb", {1'b0, rgb_o}, 4'b0101);
    btn_i = 1'b1;
    repeat (3) tick();
    breath_i = 1'b0;
    rst_i    = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_rgb",  {1'b0, rgb_o}, 4'b0001);
    chk("t6_rst_mode", {2'b0, mode_o}, 4'd0);
    btn_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("t6_release_rgb", {1'b0, rgb_o}, 4'b0001);
    repeat (10) tick();
    chk("t6_after_rgb",  {1'b0, rgb_o}, 4'b0001);
    chk("t6_after_mode", {2'b0, mode_o}, 4'd0);

    // ---- randomized activity ----
    for (int n = 0; n < 80; n++) begin
      btn_i = ~btn_i;
      repeat ($urandom_range(1, 12)) begin
        if ($urandom_range(0, 2) == 0) breath_i = ~breath_i;
        tick();
      end
      if (n == 40) begin
        rst_i = 1'b1;
        #1;
        model_reset();
        chk("rnd_rst_rgb", {1'b0, rgb_o}, 4'b0001);
        tick();
        rst_i = 1'b0;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
